// File: rtl/solution_serializer.sv
// Streams a solved board from the row BRAM to a UART byte interface: a rows/cols header,
// then the board bits row-major, column 0 first. Define SERIALIZER_CHECKSUM_EN for a trailing XOR byte.
module solution_serializer #(
  parameter int MAX_COLS = 16,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          num_rows,
  input  logic [7:0]          num_cols,
  output logic [ADDR_W-1:0]   row_addr,
  input  logic [MAX_COLS-1:0] row_data,
  output logic [7:0]          byte_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE, HDR_R, HDR_C, FETCH, SHIFT, SEND,
`ifdef SERIALIZER_CHECKSUM_EN
    CKSUM,
`endif
    FINISH
  } state_t;

`ifdef SERIALIZER_CHECKSUM_EN
  localparam state_t END_ST = CKSUM;
`else
  localparam state_t END_ST = FINISH;
`endif

  localparam logic [7:0] ROWS_MAX = 8'(2 ** ADDR_W);
  localparam logic [7:0] COLS_MAX = 8'(MAX_COLS);
  localparam logic [2:0] LAT_C    = 3'(READ_LAT);

  state_t              state_q, state_d;
  logic [7:0]          rows_q, cols_q;
  logic [7:0]          col_cnt;
  logic [2:0]          lat_cnt;
  logic [MAX_COLS-1:0] row_reg;
  logic [7:0]          acc_q, byte_q;
  logic [3:0]          acc_cnt;
  logic [15:0]         bits_left;
  logic                row_end;
  logic [7:0]          acc_n;
  logic                last_col, last_row, fire;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0]          cksum_q;
`endif

  assign acc_n    = {acc_q[6:0], row_reg[0]};
  assign last_col = (col_cnt == cols_q - 8'd1);
  assign last_row = (8'(row_addr) == rows_q - 8'd1);
  assign fire     = valid_out & ready_in;
  assign busy     = (state_q != IDLE) && (state_q != FINISH);
  assign done     = (state_q == FINISH);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    valid_out = 1'b0;
    byte_out  = 8'h00;
    case (state_q)
      IDLE:  if (start) state_d = HDR_R;
      HDR_R: begin
        valid_out = 1'b1;
        byte_out  = rows_q;
        if (ready_in) state_d = HDR_C;
      end
      HDR_C: begin
        valid_out = 1'b1;
        byte_out  = cols_q;
        if (ready_in) state_d = (rows_q == 8'd0 || cols_q == 8'd0) ? END_ST : FETCH;
      end
      FETCH: if (lat_cnt == LAT_C) state_d = SHIFT;
      SHIFT: begin
        if (acc_cnt == 4'd7 || (last_col && last_row)) state_d = SEND;
        else if (last_col)                              state_d = FETCH;
      end
      SEND: begin
        valid_out = 1'b1;
        byte_out  = byte_q;
        if (ready_in) begin
          if (bits_left == 16'd0) state_d = END_ST;
          else if (row_end)       state_d = FETCH;
          else                    state_d = SHIFT;
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      CKSUM: begin
        valid_out = 1'b1;
        byte_out  = cksum_q;
        if (ready_in) state_d = FINISH;
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_addr  <= '0;
      col_cnt   <= '0;
      lat_cnt   <= '0;
      row_reg   <= '0;
      acc_q     <= '0;
      byte_q    <= '0;
      acc_cnt   <= '0;
      bits_left <= '0;
      row_end   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          rows_q   <= (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
          cols_q   <= (num_cols > COLS_MAX) ? COLS_MAX : num_cols;
          row_addr <= '0;
          acc_q    <= '0;
          acc_cnt  <= '0;
          row_end  <= 1'b0;
        end
        HDR_C: if (ready_in) begin
          bits_left <= 16'(rows_q) * 16'(cols_q);
          row_addr  <= '0;
          lat_cnt   <= '0;
        end
        FETCH: begin
          if (lat_cnt == LAT_C) begin
            row_reg <= row_data;
            lat_cnt <= '0;
            col_cnt <= '0;
            row_end <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        SHIFT: begin
          acc_q     <= acc_n;
          row_reg   <= row_reg >> 1;
          col_cnt   <= col_cnt + 8'd1;
          bits_left <= bits_left - 16'd1;
          if (acc_cnt == 4'd7) begin
            byte_q  <= acc_n;
            acc_cnt <= '0;
          end else if (last_col && last_row) begin
            byte_q  <= acc_n << (4'd7 - acc_cnt);
            acc_cnt <= '0;
          end else begin
            acc_cnt <= acc_cnt + 4'd1;
          end
          // A full byte at a row end is sent before the next row address is issued.
          if (last_col && !last_row) begin
            if (acc_cnt == 4'd7) row_end  <= 1'b1;
            else                 row_addr <= row_addr + 1'b1;
          end
        end
        SEND: if (ready_in && row_end && bits_left != 16'd0) begin
          row_addr <= row_addr + 1'b1;
          row_end  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIALIZER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                            cksum_q <= '0;
    else if (state_q == IDLE && start)  cksum_q <= '0;
    else if (fire && state_q != CKSUM)  cksum_q <= cksum_q ^ byte_out;
  end
`else
  logic unused_fire;
  assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_solution_serializer.sv
// Scoreboard bench for solution_serializer: a bit-list reference model fills the expected byte
// queue, and a monitor checks every transfer, byte stability under backpressure and the done pulse.
module tb_solution_serializer;
  localparam int MAX_COLS = 16;
  localparam int ADDR_W   = 4;
  localparam int READ_LAT = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [7:0]          num_rows = 8'd0, num_cols = 8'd0;
  logic [ADDR_W-1:0]   row_addr;
  logic [MAX_COLS-1:0] row_data;
  logic [7:0]          byte_out;
  logic                valid_out, busy, done;
  logic                ready_in = 1'b0;

  always #5 clk = ~clk;

  solution_serializer #(.MAX_COLS(MAX_COLS), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .row_addr(row_addr), .row_data(row_data), .byte_out(byte_out), .valid_out(valid_out),
    .ready_in(ready_in), .busy(busy), .done(done)
  );

  // Board memory with a READ_LAT-deep read pipeline.
  logic [MAX_COLS-1:0] mem  [2**ADDR_W];
  logic [MAX_COLS-1:0] pipe [READ_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[row_addr];
    for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign row_data = pipe[READ_LAT-1];

  int vectors = 0, miscompares = 0;
  task automatic check(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected stream: header, then all board bits as a flat list packed MSB-first.
  logic [7:0] exp_q[$];
  task automatic push_expected(int r_in, int c_in);
    int r, c;
    bit bits[$];
    logic [7:0] b, x;
    r = (r_in > 2**ADDR_W) ? 2**ADDR_W : r_in;
    c = (c_in > MAX_COLS) ? MAX_COLS : c_in;
    exp_q.push_back(8'(r));
    exp_q.push_back(8'(c));
    x = 8'(r) ^ 8'(c);
    for (int rr = 0; rr < r; rr++)
      for (int cc = 0; cc < c; cc++) bits.push_back(mem[rr][cc]);
    for (int i = 0; i < bits.size(); i += 8) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], (i + k < bits.size()) ? bits[i+k] : 1'b0};
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef SERIALIZER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Ready driver: 0 = always, 1 = toggle, 2 = random, 3 = held low.
  int ready_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       ready_in = 1'b1;
      1:       ready_in = ~ready_in;
      2:       ready_in = 1'($urandom_range(0, 1));
      default: ready_in = 1'b0;
    endcase
  end

  // Monitor: samples on the falling edge, between driver updates and the active edge.
  int xfer_cnt = 0, addr_changes = 0;
  bit done_expect = 0, done_seen = 0, hold = 0;
  logic [7:0] held = 8'h00;
  logic [ADDR_W-1:0] last_addr = '0;
  always @(negedge clk) begin
    if (row_addr !== last_addr) addr_changes++;
    last_addr = row_addr;
    if (rst) begin
      hold = 0;
      done_expect = 0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(valid_out), 1);
        check("hold_byte", 32'(byte_out), 32'(held));
      end
      if (done_expect) begin
        check("done_pulse", 32'(done), 1);
        if (done) done_seen = 1;
        done_expect = 0;
      end else if (done) begin
        check("spurious_done", 32'(done), 0);
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(byte_out), -1);
        else begin
          check($sformatf("byte%0d", xfer_cnt), 32'(byte_out), 32'(exp_q.pop_front()));
          if (exp_q.size() == 0) done_expect = 1;
        end
        xfer_cnt++;
      end
      hold = valid_out && !ready_in;
      held = byte_out;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(int r, int c);
    num_rows = 8'(r);
    num_cols = 8'(c);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int cyc = 0;
    while (!done_seen && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    check({name, "_done"}, 32'(done_seen), 1);
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_xfers(int n, string name);
    int cyc = 0;
    while (xfer_cnt < n && cyc < 500) begin
      tick(1);
      cyc++;
    end
    check({name, "_xfers"}, 32'(xfer_cnt >= n), 1);
  endtask

  task automatic run(string name, int r, int c);
    done_seen = 0;
    push_expected(r, c);
    do_start(r, c);
    wait_done(name);
    tick(2);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    rst = 1'b1;
    tick(3);
    check("rst_row_addr", 32'(row_addr), 0);
    check("rst_byte_out", 32'(byte_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick(2);

    // 2x4 with ready tied high.
    mem[0] = 16'h0005; mem[1] = 16'h000F;
    ready_mode = 0;
    run("t1", 2, 4);

    // 3x3 diagonal with ready toggling.
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0004;
    ready_mode = 1;
    run("t2", 3, 3);

    // 2x8 with a 20-cycle stall right after the header.
    mem[0] = 16'h00A5; mem[1] = 16'h003C;
    ready_mode = 0;
    done_seen = 0;
    base = xfer_cnt;
    push_expected(2, 8);
    do_start(2, 8);
    wait_xfers(base + 2, "t3_hdr");
    ready_mode = 3;
    ready_in = 1'b0;
    base = addr_changes;
    tick(20);
    check("t3_stall_reads", addr_changes - base, 0);
    ready_mode = 0;
    wait_done("t3");
    tick(2);

    // Empty board; a second start while busy must be ignored.
    done_seen = 0;
    push_expected(0, 5);
    do_start(0, 5);
    check("t4_busy", 32'(busy), 1);
    do_start(3, 3);
    wait_done("t4");
    tick(6);
    check("t4_idle_valid", 32'(valid_out), 0);
    check("t4_idle_busy", 32'(busy), 0);

    // Full 16x16 board of ones, column count clamped from 40.
    for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
    run("t5", 16, 40);

    // Reset after the third transfer, then a fresh stream.
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    done_seen = 0;
    base = xfer_cnt;
    push_expected(4, 8);
    do_start(4, 8);
    wait_xfers(base + 3, "t6");
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    check("t6_rst_valid", 32'(valid_out), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    rst = 1'b0;
    tick(10);
    check("t6_no_done", 32'(done_seen), 0);
    run("t6b", 4, 8);

    // Randomized boards and sizes, including clamped ones, under random backpressure.
    ready_mode = 2;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      run($sformatf("rnd%0d", n), int'($urandom_range(0, 18)), int'($urandom_range(0, 20)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
